io_bus_ctrl: RTL and testbench

//  Sequencer between the core's load/store path and io_mem's shared 8-bit tristate bus.
//  - Takes single read/write requests on a valid/ready handshake.
//  - Drives io_mem's r_addr/w_addr and owns the bus drive-enable, with a turnaround cycle after every access.
//  - Returns one response pulse per request.
//  - Bus protocol: address IDLE_ADDR is reserved (no access). io_mem drives bus while r_addr!=IDLE_ADDR;
//    it writes bus on clk rising edge while w_addr!=IDLE_ADDR.

---
 rtl/io_bus_ctrl.sv | 146 ++++++++++++++
 tb/tb_io_bus_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : io_bus_ctrl
// Description : Sequencer between a load/store request port and io_mem's shared
//               8-bit tristate bus, with a turnaround cycle after every access.
// Revision    : 1.0 - initial release
// ============================================================================
module io_bus_ctrl #(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 8,
    parameter int                RD_WAIT   = 1,
    parameter logic [ADDR_W-1:0] IDLE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] r_addr,
    output logic [ADDR_W-1:0] w_addr,
    inout  wire  [DATA_W-1:0] bus
);

    localparam logic [3:0] c_rd_reload = 4'(RD_WAIT);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WR_DRIVE = 2'd1,
        S_RD_HOLD  = 2'd2,
        S_TURN     = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              drive_q, drive_d;
    logic              ready_q, ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_W-1:0] r_addr_q, r_addr_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= IDLE_ADDR;
            wdata_q     <= '0;
            cnt_q       <= '0;
            drive_q     <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            r_addr_q    <= IDLE_ADDR;
            w_addr_q    <= IDLE_ADDR;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            drive_q     <= drive_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            r_addr_q    <= r_addr_d;
            w_addr_q    <= w_addr_d;
        end
    end

    // Every bus-facing output is computed one state ahead so it is registered
    // in the cycle the state it belongs to is active.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        drive_d     = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        r_addr_d    = IDLE_ADDR;
        w_addr_d    = IDLE_ADDR;
        case (state_q)
            S_IDLE: begin
                if (req_valid && ready_q) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (req_addr == IDLE_ADDR) begin
                        state_d     = S_TURN;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (req_we) begin
                        state_d  = S_WR_DRIVE;
                        w_addr_d = req_addr;
                        drive_d  = 1'b1;
                    end else begin
                        state_d  = S_RD_HOLD;
                        r_addr_d = req_addr;
                        cnt_d    = c_rd_reload;
                    end
                end
            end
            S_WR_DRIVE: begin
                state_d     = S_TURN;
                rsp_valid_d = 1'b1;
            end
            S_RD_HOLD: begin
                if (cnt_q == 4'd0) begin
                    rsp_rdata_d = bus;
                    state_d     = S_TURN;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d    = cnt_q - 4'd1;
                    r_addr_d = addr_q;
                end
            end
            S_TURN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        ready_d = (state_d == S_IDLE);
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign r_addr    = r_addr_q;
    assign w_addr    = w_addr_q;
    // drive_q clears asynchronously on reset, releasing the bus immediately
    assign bus       = drive_q ? wdata_q : {DATA_W{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_io_bus_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_io_bus_ctrl
// Description : Self-checking bench for io_bus_ctrl with io_mem models on three
//               instances (RD_WAIT = 1, 0, 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_bus_ctrl;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       req_valid [N];
    logic       req_we    [N];
    logic [7:0] req_addr  [N];
    logic [7:0] req_wdata [N];
    wire        req_ready [N];
    wire        rsp_valid [N];
    wire        rsp_err   [N];
    wire  [7:0] rsp_rdata [N];
    wire  [7:0] r_addr    [N];
    wire  [7:0] w_addr    [N];
    wire  [7:0] bus_obs   [N];

    logic [7:0] sb [N][256];
    int n_cmp = 0;
    int n_mis = 0;

    function automatic logic [7:0] init_val(input int a);
        return 8'((a * 37 + 11) & 255);
    endfunction

    function automatic int rdw_of(input int idx);
        return (idx == 0) ? 1 : (idx == 1) ? 0 : 3;
    endfunction

    generate
        for (genvar g = 0; g < N; g++) begin : g_inst
            localparam int RDW = (g == 0) ? 1 : (g == 1) ? 0 : 3;
            wire  [7:0] bus;
            logic [7:0] mem [256];

            io_bus_ctrl #(
                .ADDR_W   (8),
                .DATA_W   (8),
                .RD_WAIT  (RDW),
                .IDLE_ADDR(8'h00)
            ) u_dut (
                .clk      (clk),
                .rst_n    (rst_n),
                .req_valid(req_valid[g]),
                .req_ready(req_ready[g]),
                .req_we   (req_we[g]),
                .req_addr (req_addr[g]),
                .req_wdata(req_wdata[g]),
                .rsp_valid(rsp_valid[g]),
                .rsp_err  (rsp_err[g]),
                .rsp_rdata(rsp_rdata[g]),
                .r_addr   (r_addr[g]),
                .w_addr   (w_addr[g]),
                .bus      (bus)
            );

            // io_mem: drives while r_addr is live, captures while w_addr is live
            assign bus = (r_addr[g] != 8'h00) ? mem[r_addr[g]] : 8'bzzzzzzzz;
            assign bus_obs[g] = bus;
            initial for (int a = 0; a < 256; a++) mem[a] = init_val(a);
            always @(posedge clk) if (w_addr[g] != 8'h00) mem[w_addr[g]] <= bus;
        end
    endgenerate

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < N; i++) begin
            n_cmp++; if (req_ready[i] !== 1'b0) begin n_mis++; $display("FAIL reset_ready[%0d]: got %b expected 0", i, req_ready[i]); end
            n_cmp++; if (rsp_valid[i] !== 1'b0 || rsp_err[i] !== 1'b0) begin n_mis++; $display("FAIL reset_rsp[%0d]: got valid=%b err=%b expected 0/0", i, rsp_valid[i], rsp_err[i]); end
            n_cmp++; if (rsp_rdata[i] !== 8'h00) begin n_mis++; $display("FAIL reset_rdata[%0d]: got %h expected 00", i, rsp_rdata[i]); end
            n_cmp++; if (r_addr[i] !== 8'h00 || w_addr[i] !== 8'h00) begin n_mis++; $display("FAIL reset_addr[%0d]: got r=%h w=%h expected 00/00", i, r_addr[i], w_addr[i]); end
        end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (req_ready[0] !== 1'b0) begin n_mis++; $display("FAIL ready_before_edge: got %b expected 0", req_ready[0]); end
        tick();
        for (int i = 0; i < N; i++) begin
            n_cmp++; if (req_ready[i] !== 1'b1) begin n_mis++; $display("FAIL ready_after_release[%0d]: got %b expected 1", i, req_ready[i]); end
        end
    endtask

    task automatic test_write();
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 8'h12; req_wdata[0] = 8'h5A;
        tick();
        req_valid[0] = 1'b0; req_addr[0] = 8'h77; req_wdata[0] = 8'h11;
        n_cmp++; if (w_addr[0] !== 8'h12 || r_addr[0] !== 8'h00) begin n_mis++; $display("FAIL wr_c1_addr: got w=%h r=%h expected 12/00", w_addr[0], r_addr[0]); end
        n_cmp++; if (bus_obs[0] !== 8'h5A) begin n_mis++; $display("FAIL wr_c1_bus: got %h expected 5a", bus_obs[0]); end
        n_cmp++; if (req_ready[0] !== 1'b0 || rsp_valid[0] !== 1'b0) begin n_mis++; $display("FAIL wr_c1_ctl: got ready=%b rsp=%b expected 0/0", req_ready[0], rsp_valid[0]); end
        tick();
        n_cmp++; if (w_addr[0] !== 8'h00 || r_addr[0] !== 8'h00) begin n_mis++; $display("FAIL wr_c2_addr: got w=%h r=%h expected 00/00", w_addr[0], r_addr[0]); end
        n_cmp++; if (rsp_valid[0] !== 1'b1 || rsp_err[0] !== 1'b0 || req_ready[0] !== 1'b0) begin n_mis++; $display("FAIL wr_c2_rsp: got rsp=%b err=%b ready=%b expected 1/0/0", rsp_valid[0], rsp_err[0], req_ready[0]); end
        n_cmp++; if (bus_obs[0] !== 8'bzzzzzzzz && bus_obs[0] !== 8'h00) begin n_mis++; $display("FAIL wr_c2_bus: got %h expected released", bus_obs[0]); end
        n_cmp++; if (g_inst[0].mem[8'h12] !== 8'h5A) begin n_mis++; $display("FAIL wr_mem: got %h expected 5a", g_inst[0].mem[8'h12]); end
        tick();
        n_cmp++; if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin n_mis++; $display("FAIL wr_c3: got rsp=%b ready=%b expected 0/1", rsp_valid[0], req_ready[0]); end
        sb[0][8'h12] = 8'h5A;
    endtask

    task automatic test_read();
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 8'h12;
        tick();
        req_valid[0] = 1'b0;
        n_cmp++; if (r_addr[0] !== 8'h12 || w_addr[0] !== 8'h00) begin n_mis++; $display("FAIL rd_c1_addr: got r=%h w=%h expected 12/00", r_addr[0], w_addr[0]); end
        n_cmp++; if (bus_obs[0] !== 8'h5A) begin n_mis++; $display("FAIL rd_c1_bus: got %h expected 5a", bus_obs[0]); end
        tick();
        n_cmp++; if (r_addr[0] !== 8'h12 || rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b0) begin n_mis++; $display("FAIL rd_c2: got r=%h rsp=%b ready=%b expected 12/0/0", r_addr[0], rsp_valid[0], req_ready[0]); end
        tick();
        n_cmp++; if (r_addr[0] !== 8'h00 || rsp_valid[0] !== 1'b1 || rsp_err[0] !== 1'b0 || req_ready[0] !== 1'b0) begin n_mis++; $display("FAIL rd_c3: got r=%h rsp=%b err=%b ready=%b expected 00/1/0/0", r_addr[0], rsp_valid[0], rsp_err[0], req_ready[0]); end
        n_cmp++; if (rsp_rdata[0] !== 8'h5A) begin n_mis++; $display("FAIL rd_data: got %h expected 5a", rsp_rdata[0]); end
        tick();
        n_cmp++; if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0) begin n_mis++; $display("FAIL rd_c4: got ready=%b rsp=%b expected 1/0", req_ready[0], rsp_valid[0]); end
    endtask

    task automatic test_back_to_back();
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 8'h30; req_wdata[0] = 8'hA5;
        tick();
        req_we[0] = 1'b0; req_addr[0] = 8'h30; req_wdata[0] = 8'h00;
        n_cmp++; if (w_addr[0] !== 8'h30 || bus_obs[0] !== 8'hA5 || req_ready[0] !== 1'b0) begin n_mis++; $display("FAIL b2b_c1: got w=%h bus=%h ready=%b expected 30/a5/0", w_addr[0], bus_obs[0], req_ready[0]); end
        tick();
        n_cmp++; if (r_addr[0] !== 8'h00 || w_addr[0] !== 8'h00 || rsp_valid[0] !== 1'b1) begin n_mis++; $display("FAIL b2b_turn: got r=%h w=%h rsp=%b expected 00/00/1", r_addr[0], w_addr[0], rsp_valid[0]); end
        n_cmp++; if (bus_obs[0] !== 8'bzzzzzzzz && bus_obs[0] !== 8'h00) begin n_mis++; $display("FAIL b2b_turn_bus: got %h expected released", bus_obs[0]); end
        tick();
        n_cmp++; if (req_ready[0] !== 1'b1 || r_addr[0] !== 8'h00) begin n_mis++; $display("FAIL b2b_c3: got ready=%b r=%h expected 1/00", req_ready[0], r_addr[0]); end
        tick();
        req_valid[0] = 1'b0;
        n_cmp++; if (r_addr[0] !== 8'h30 || req_ready[0] !== 1'b0) begin n_mis++; $display("FAIL b2b_second_accept: got r=%h ready=%b expected 30/0", r_addr[0], req_ready[0]); end
        tick();
        tick();
        n_cmp++; if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 8'hA5) begin n_mis++; $display("FAIL b2b_rd: got rsp=%b data=%h expected 1/a5", rsp_valid[0], rsp_rdata[0]); end
        tick();
        n_cmp++; if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0) begin n_mis++; $display("FAIL b2b_end: got ready=%b rsp=%b expected 1/0", req_ready[0], rsp_valid[0]); end
        sb[0][8'h30] = 8'hA5;
    endtask

    task automatic test_error();
        for (int we = 0; we < 2; we++) begin
            req_valid[0] = 1'b1; req_we[0] = 1'(we); req_addr[0] = 8'h00; req_wdata[0] = 8'hC3;
            tick();
            req_valid[0] = 1'b0;
            n_cmp++; if (rsp_valid[0] !== 1'b1 || rsp_err[0] !== 1'b1 || req_ready[0] !== 1'b0) begin n_mis++; $display("FAIL err_c1[we=%0d]: got rsp=%b err=%b ready=%b expected 1/1/0", we, rsp_valid[0], rsp_err[0], req_ready[0]); end
            n_cmp++; if (r_addr[0] !== 8'h00 || w_addr[0] !== 8'h00) begin n_mis++; $display("FAIL err_addr[we=%0d]: got r=%h w=%h expected 00/00", we, r_addr[0], w_addr[0]); end
            n_cmp++; if (bus_obs[0] !== 8'bzzzzzzzz && bus_obs[0] !== 8'h00) begin n_mis++; $display("FAIL err_bus[we=%0d]: got %h expected released", we, bus_obs[0]); end
            n_cmp++; if (rsp_rdata[0] !== 8'hA5) begin n_mis++; $display("FAIL err_rdata[we=%0d]: got %h expected a5", we, rsp_rdata[0]); end
            tick();
            n_cmp++; if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0 || rsp_err[0] !== 1'b0) begin n_mis++; $display("FAIL err_c2[we=%0d]: got ready=%b rsp=%b err=%b expected 1/0/0", we, req_ready[0], rsp_valid[0], rsp_err[0]); end
        end
    endtask

    task automatic test_reset_mid_read();
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 8'h30;
        tick();
        req_valid[0] = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (r_addr[0] !== 8'h00 || req_ready[0] !== 1'b0 || rsp_valid[0] !== 1'b0) begin n_mis++; $display("FAIL rst_mid: got r=%h ready=%b rsp=%b expected 00/0/0", r_addr[0], req_ready[0], rsp_valid[0]); end
        n_cmp++; if (bus_obs[0] !== 8'bzzzzzzzz && bus_obs[0] !== 8'h00) begin n_mis++; $display("FAIL rst_mid_bus: got %h expected released", bus_obs[0]); end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        n_cmp++; if (req_ready[0] !== 1'b0) begin n_mis++; $display("FAIL rst_release_ready: got %b expected 0", req_ready[0]); end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++; if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin n_mis++; $display("FAIL rst_after[%0d]: got rsp=%b ready=%b expected 0/1", k, rsp_valid[0], req_ready[0]); end
        end
        n_cmp++; if (rsp_rdata[0] !== 8'h00) begin n_mis++; $display("FAIL rst_rdata: got %h expected 00", rsp_rdata[0]); end
    endtask

    // Model: each request has a fixed response latency (error 1, write 2,
    // read RD_WAIT+2); address/bus activity follows from the access window.
    task automatic test_random(input int idx, input int n);
        int         rdw = rdw_of(idx);
        logic [7:0] last = 8'h00;
        int         resp_seen = 0;
        for (int t = 0; t < n; t++) begin
            logic       we, err;
            logic [7:0] addr, wd, exp_rd, exp_r, exp_w, exp_data;
            int         lat;
            if ($urandom_range(0, 3) == 0) begin
                req_valid[idx] = 1'b0;
                repeat ($urandom_range(1, 2)) begin
                    tick();
                    n_cmp++; if (req_ready[idx] !== 1'b1 || rsp_valid[idx] !== 1'b0) begin n_mis++; $display("FAIL rnd_gap[%0d]: got ready=%b rsp=%b expected 1/0", idx, req_ready[idx], rsp_valid[idx]); end
                end
            end
            we   = 1'($urandom_range(0, 1));
            addr = 8'($urandom_range(0, 7));
            wd   = 8'($urandom);
            req_valid[idx] = 1'b1; req_we[idx] = we; req_addr[idx] = addr; req_wdata[idx] = wd;
            tick();
            err    = (addr == 8'h00);
            lat    = err ? 1 : (we ? 2 : rdw + 2);
            exp_rd = sb[idx][addr];
            if (!err && we) sb[idx][addr] = wd;
            for (int k = 1; k <= lat + 1; k++) begin
                if (k > 1) tick();
                req_valid[idx] = 1'($urandom_range(0, 1));
                req_we[idx]    = 1'($urandom_range(0, 1));
                req_addr[idx]  = 8'($urandom);
                req_wdata[idx] = 8'($urandom);
                exp_r    = (!err && !we && k <= rdw + 1) ? addr : 8'h00;
                exp_w    = (!err && we && k == 1) ? addr : 8'h00;
                exp_data = (!err && !we && k >= lat) ? exp_rd : last;
                if (rsp_valid[idx] === 1'b1) resp_seen++;
                n_cmp++; if (r_addr[idx] !== exp_r || w_addr[idx] !== exp_w) begin n_mis++; $display("FAIL rnd_addr[%0d] t=%0d k=%0d: got r=%h w=%h expected %h/%h", idx, t, k, r_addr[idx], w_addr[idx], exp_r, exp_w); end
                n_cmp++; if (r_addr[idx] !== 8'h00 && w_addr[idx] !== 8'h00) begin n_mis++; $display("FAIL rnd_contention[%0d]: got r=%h w=%h expected one idle", idx, r_addr[idx], w_addr[idx]); end
                if (exp_w != 8'h00) begin
                    n_cmp++; if (bus_obs[idx] !== wd) begin n_mis++; $display("FAIL rnd_bus_wr[%0d]: got %h expected %h", idx, bus_obs[idx], wd); end
                end else if (exp_r != 8'h00) begin
                    n_cmp++; if (bus_obs[idx] !== exp_rd) begin n_mis++; $display("FAIL rnd_bus_rd[%0d]: got %h expected %h", idx, bus_obs[idx], exp_rd); end
                end else begin
                    n_cmp++; if (bus_obs[idx] !== 8'bzzzzzzzz && bus_obs[idx] !== 8'h00) begin n_mis++; $display("FAIL rnd_bus_idle[%0d]: got %h expected released", idx, bus_obs[idx]); end
                end
                n_cmp++; if (rsp_valid[idx] !== 1'(k == lat) || rsp_err[idx] !== 1'(k == lat && err)) begin n_mis++; $display("FAIL rnd_rsp[%0d] t=%0d k=%0d: got rsp=%b err=%b expected %b/%b", idx, t, k, rsp_valid[idx], rsp_err[idx], k == lat, k == lat && err); end
                n_cmp++; if (req_ready[idx] !== 1'(k == lat + 1)) begin n_mis++; $display("FAIL rnd_ready[%0d] t=%0d k=%0d: got %b expected %b", idx, t, k, req_ready[idx], k == lat + 1); end
                n_cmp++; if (rsp_rdata[idx] !== exp_data) begin n_mis++; $display("FAIL rnd_rdata[%0d] t=%0d k=%0d: got %h expected %h", idx, t, k, rsp_rdata[idx], exp_data); end
            end
            if (!err && !we) last = exp_rd;
        end
        req_valid[idx] = 1'b0;
        n_cmp++; if (resp_seen != n) begin n_mis++; $display("FAIL rnd_resp_count[%0d]: got %0d expected %0d", idx, resp_seen, n); end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = 8'h00; req_wdata[i] = 8'h00;
            for (int a = 0; a < 256; a++) sb[i][a] = init_val(a);
        end
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_error();
        test_reset_mid_read();
        test_random(1, 60);
        test_random(2, 60);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
